// File: rtl/vec_pkg.sv
// vec_pkg: shared types and helpers for the VecFIFO drain engine.
package vec_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        WRAP,
        READ,
        FLUSH
    } drain_state_t;

    function automatic int beats_of(input int vec_elems, input int bytes_per_read);
        return vec_elems / bytes_per_read;
    endfunction

endpackage

// File: rtl/vec_fifo_drain_if.sv
// vec_fifo_drain_if: byte-lane valid/ready stream carrying drained vector beats.
interface vec_fifo_drain_if #(
    parameter int BytesPerRead = 1
);
    import vec_pkg::*;

    byte_t [BytesPerRead-1:0] data;
    logic                     valid;
    logic                     ready;
    logic                     last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/byte_skid_buf.sv
// byte_skid_buf: 2-entry register FIFO holding returned read chunks.
module byte_skid_buf
    import vec_pkg::*;
#(
    parameter int BytesPerRead = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic                     pop,
    input  byte_t [BytesPerRead-1:0] din,
    output byte_t [BytesPerRead-1:0] dout,
    output logic  [1:0]              occ
);
    byte_t [BytesPerRead-1:0] e0;
    byte_t [BytesPerRead-1:0] e1;

    // e0 is always the head; e1 only holds data when two entries are queued
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= din;
                    else             e1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = e0;

endmodule

// File: rtl/vec_fifo_drain.sv
// vec_fifo_drain: rewinds the VecFIFO and streams one finished vector
// out as valid/ready beats with a last marker.
module vec_fifo_drain
    import vec_pkg::*;
#(
    parameter int VecElements  = 8,
    parameter int BytesPerRead = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     vec_valid_in,
    output logic                     fifo_wrap_rd,
    output logic                     fifo_rd_en,
    input  byte_t [BytesPerRead-1:0] fifo_rd_data,
    vec_fifo_drain_if.master         m,
    output logic                     busy_out,
    output logic                     drain_done,
    output logic                     overrun
);
    localparam int Beats = beats_of(VecElements, BytesPerRead);
    localparam int CntW  = $clog2(Beats + 1);
    localparam logic [CntW-1:0] BeatsC  = CntW'(Beats);
    localparam logic [CntW-1:0] LastIdx = CntW'(Beats - 1);

    if (VecElements < 1 || BytesPerRead < 1 ||
        (VecElements % BytesPerRead) != 0) begin : g_bad_params
        $error("VecElements must be a positive multiple of BytesPerRead");
    end

    drain_state_t             state;
    drain_state_t             state_nx;
    logic [CntW-1:0]          issued;
    logic [CntW-1:0]          emitted;
    logic                     pending;
    logic                     inflight;
    logic                     pop;
    logic                     credit_ok;
    logic [1:0]               occ;
    byte_t [BytesPerRead-1:0] head;

    byte_skid_buf #(.BytesPerRead(BytesPerRead)) u_skid (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (inflight),
        .pop    (pop),
        .din    (fifo_rd_data),
        .dout   (head),
        .occ    (occ)
    );

    assign pop      = m.valid & m.ready;
    assign m.valid  = (occ != 2'd0);
    assign m.data   = head;
    assign m.last   = m.valid & (emitted == LastIdx);
    assign busy_out = (state != IDLE);

    // held + in-flight entries, less the one leaving now, must leave a free slot
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_nx     = state;
        fifo_wrap_rd = 1'b0;
        fifo_rd_en   = 1'b0;
        drain_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (vec_valid_in || pending) state_nx = WRAP;
            end
            WRAP: begin
                fifo_wrap_rd = 1'b1;
                state_nx     = READ;
            end
            READ: begin
                fifo_rd_en = (issued < BeatsC) && credit_ok;
                if (fifo_rd_en && issued == LastIdx) state_nx = FLUSH;
            end
            FLUSH: begin
                if (emitted == BeatsC) begin
                    drain_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            issued   <= '0;
            emitted  <= '0;
            inflight <= 1'b0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= fifo_rd_en;
            if (state == WRAP)   issued <= '0;
            else if (fifo_rd_en) issued <= issued + CntW'(1);
            if (state == WRAP)   emitted <= '0;
            else if (pop)        emitted <= emitted + CntW'(1);
            if (vec_valid_in && (state != IDLE || pending)) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
            // the queued request is consumed as IDLE launches it
            if (state == IDLE && pending) pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_fifo_drain.sv
// tb_vec_fifo_drain: randomized scenario bench for the VecFIFO drain engine,
// byte-wide and 2-byte-wide instances side by side.
module tb_vec_fifo_drain;
    import vec_pkg::*;

    typedef struct {
        byte_t [1:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vv  = 1'b0;
    logic rdy = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    byte_t mem [8];

    logic wrap_a, rd_a, busy_a, done_a, ovr_a;
    logic wrap_b, rd_b, busy_b, done_b, ovr_b;
    byte_t [0:0] rdat_a = '0;
    byte_t [1:0] rdat_b = '0;

    vec_fifo_drain_if #(.BytesPerRead(1)) if_a ();
    vec_fifo_drain_if #(.BytesPerRead(2)) if_b ();
    assign if_a.ready = rdy;
    assign if_b.ready = rdy;

    vec_fifo_drain #(.VecElements(8), .BytesPerRead(1)) dut_a (
        .clk_in(clk), .rst_in(rst), .vec_valid_in(vv),
        .fifo_wrap_rd(wrap_a), .fifo_rd_en(rd_a), .fifo_rd_data(rdat_a),
        .m(if_a), .busy_out(busy_a), .drain_done(done_a), .overrun(ovr_a)
    );

    vec_fifo_drain #(.VecElements(8), .BytesPerRead(2)) dut_b (
        .clk_in(clk), .rst_in(rst), .vec_valid_in(vv),
        .fifo_wrap_rd(wrap_b), .fifo_rd_en(rd_b), .fifo_rd_data(rdat_b),
        .m(if_b), .busy_out(busy_b), .drain_done(done_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    // VecFIFO read-side model: rewind on wrap, 1-cycle read latency
    int   ptr_a = 0;
    int   ptr_b = 0;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;

    always @(negedge clk) begin
        if (wrap_a) ptr_a = 0;
        if (wrap_b) ptr_b = 0;
        pend_a = rd_a;
        pend_b = rd_b;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend_a) begin
            rdat_a[0] = mem[ptr_a % 8];
            ptr_a++;
        end
        if (pend_b) begin
            rdat_b[0] = mem[(2 * ptr_b) % 8];
            rdat_b[1] = mem[(2 * ptr_b + 1) % 8];
            ptr_b++;
        end
    end

    // event recorder
    beat_t qa[$];
    beat_t qb[$];
    int    wraps[$];
    int    dones_a[$];
    int    dones_b[$];
    int    rises[$];
    int    falls[$];
    int    rdcnt, popcnt, maxout, stable_err, overlap;
    logic  held, held_l, busy_prev;
    byte_t held_d;

    always @(negedge clk) begin
        if (!rst) begin
            if (wrap_a) wraps.push_back(cyc);
            if (wrap_a && rd_a) overlap++;
            if (done_a) dones_a.push_back(cyc);
            if (done_b) dones_b.push_back(cyc);
            if (busy_a && !busy_prev) rises.push_back(cyc);
            if (!busy_a && busy_prev) falls.push_back(cyc);
            busy_prev = busy_a;
            if (rd_a) rdcnt++;
            if (held && if_a.valid &&
                (if_a.data[0] !== held_d || if_a.last !== held_l)) stable_err++;
            held   = if_a.valid && !rdy;
            held_d = if_a.data[0];
            held_l = if_a.last;
            if (if_a.valid && rdy) begin
                qa.push_back('{{8'h00, if_a.data[0]}, if_a.last, cyc});
                popcnt++;
            end
            if (rdcnt - popcnt > maxout) maxout = rdcnt - popcnt;
            if (if_b.valid && rdy) qb.push_back('{if_b.data, if_b.last, cyc});
        end
    end

    task automatic clear_logs();
        qa.delete(); qb.delete(); wraps.delete();
        dones_a.delete(); dones_b.delete(); rises.delete(); falls.delete();
        rdcnt = 0; popcnt = 0; maxout = 0; stable_err = 0; overlap = 0;
        held = 1'b0; held_l = 1'b0; held_d = '0; busy_prev = busy_a;
    endtask

    task automatic tick(input logic v, input logic r);
        @(posedge clk);
        #1;
        vv  = v;
        rdy = r;
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 8; i++) mem[i] = rnd ? byte_t'($urandom) : byte_t'(i);
    endtask

    function automatic int first_or(input int q[$]);
        return (q.size() == 1) ? q[0] : -1;
    endfunction

    task automatic test_reset();
        logic [15:0] g;
        rst = 1'b1;
        vv  = 1'b0;
        @(posedge clk);
        #2;
        g = {wrap_a, rd_a, if_a.valid, if_a.last, busy_a, done_a, ovr_a, if_a.data};
        total++;
        if (g !== 16'h0) begin bad++; $display("FAIL reset_outs_a: got %h want 0", g); end
        g = {1'b0, wrap_b, rd_b, if_b.valid, if_b.last, busy_b, done_b, ovr_b, 8'h00};
        total++;
        if (g !== 16'h0 || if_b.data !== 16'h0) begin
            bad++; $display("FAIL reset_outs_b: got %h/%h want 0", g, if_b.data);
        end
        #1 rst = 1'b0;
        clear_logs();
        repeat (4) tick(1'b0, 1'b1);
        total++;
        if ({busy_a, if_a.valid, rdcnt} !== 34'h0) begin
            bad++; $display("FAIL idle_quiet: busy=%b valid=%b rd=%0d want 0", busy_a, if_a.valid, rdcnt);
        end
    endtask

    task automatic test_nominal();
        int t0;
        logic [48:0] g, e;
        fill(1'b0);
        clear_logs();
        tick(1'b1, 1'b1);
        t0 = cyc;
        repeat (20) tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            e = {8'h00, mem[i], (i == 7), t0 + 4 + i};
            g = (i < qa.size()) ? {qa[i].data, qa[i].last, qa[i].cyc} : 'x;
            total++;
            if (g !== e) begin bad++; $display("FAIL nominal_beat%0d: got %h want %h", i, g, e); end
        end
        total++;
        if (qa.size() != 8) begin bad++; $display("FAIL nominal_count: got %0d want 8", qa.size()); end
        total++;
        if (first_or(wraps) != t0 + 1) begin
            bad++; $display("FAIL nominal_wrap_cyc: got %0d want %0d", first_or(wraps), t0 + 1);
        end
        total++;
        if (first_or(dones_a) != t0 + 12) begin
            bad++; $display("FAIL nominal_done_cyc: got %0d want %0d", first_or(dones_a), t0 + 12);
        end
        total++;
        if (rdcnt != 8) begin bad++; $display("FAIL nominal_rd_count: got %0d want 8", rdcnt); end
        total++;
        if (overlap != 0) begin bad++; $display("FAIL wrap_rd_overlap: got %0d want 0", overlap); end
        total++;
        if (first_or(rises) != t0 + 1 || first_or(falls) != t0 + 13) begin
            bad++;
            $display("FAIL busy_window: got %0d..%0d want %0d..%0d",
                     first_or(rises), first_or(falls), t0 + 1, t0 + 13);
        end
    endtask

    task automatic test_backpressure(input bit rnd);
        logic [8:0] g, e;
        fill(rnd);
        clear_logs();
        tick(1'b1, 1'b1);
        for (int k = 1; k < 60; k++) tick(1'b0, rnd ? 1'($urandom) : ((k % 3) == 0));
        repeat (5) tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            e = {mem[i], (i == 7)};
            g = (i < qa.size()) ? {qa[i].data[0], qa[i].last} : 'x;
            total++;
            if (g !== e) begin bad++; $display("FAIL bp%0d_beat%0d: got %h want %h", rnd, i, g, e); end
        end
        total++;
        if (qa.size() != 8 || rdcnt != 8 || dones_a.size() != 1) begin
            bad++;
            $display("FAIL bp%0d_counts: beats=%0d rd=%0d done=%0d want 8/8/1",
                     rnd, qa.size(), rdcnt, dones_a.size());
        end
        total++;
        if (stable_err != 0) begin bad++; $display("FAIL bp%0d_stall_stable: got %0d want 0", rnd, stable_err); end
        total++;
        if (maxout != 2) begin bad++; $display("FAIL bp%0d_credit: got %0d want 2", rnd, maxout); end
    endtask

    task automatic test_wide();
        int t0;
        logic [48:0] g, e;
        fill(1'b1);
        clear_logs();
        tick(1'b1, 1'b1);
        t0 = cyc;
        repeat (15) tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            e = {mem[2 * i + 1], mem[2 * i], (i == 3), t0 + 4 + i};
            g = (i < qb.size()) ? {qb[i].data, qb[i].last, qb[i].cyc} : 'x;
            total++;
            if (g !== e) begin bad++; $display("FAIL wide_beat%0d: got %h want %h", i, g, e); end
        end
        total++;
        if (qb.size() != 4 || first_or(dones_b) != t0 + 8) begin
            bad++;
            $display("FAIL wide_done: beats=%0d done=%0d want 4/%0d", qb.size(), first_or(dones_b), t0 + 8);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [8:0] g, e;
        fill(1'b1);
        clear_logs();
        tick(1'b1, 1'b1);
        t0 = cyc;
        repeat (4) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        total++;
        if (wraps.size() != 2 || wraps[0] != t0 + 1 || wraps[1] != t0 + 14) begin
            bad++; $display("FAIL b2b_wraps: got n=%0d want %0d,%0d", wraps.size(), t0 + 1, t0 + 14);
        end
        total++;
        if (dones_a.size() != 2 || dones_a[1] != t0 + 25) begin
            bad++; $display("FAIL b2b_done2: got n=%0d want second at %0d", dones_a.size(), t0 + 25);
        end
        for (int i = 0; i < 16; i++) begin
            e = {mem[i % 8], ((i % 8) == 7)};
            g = (i < qa.size()) ? {qa[i].data[0], qa[i].last} : 'x;
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, g, e); end
        end
        total++;
        if (ovr_a !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", ovr_a); end
    endtask

    task automatic test_overrun();
        fill(1'b1);
        clear_logs();
        tick(1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        repeat (45) tick(1'b0, 1'b1);
        total++;
        if (ovr_a !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", ovr_a); end
        total++;
        if (wraps.size() != 2 || qa.size() != 16) begin
            bad++; $display("FAIL overrun_drains: wraps=%0d beats=%0d want 2/16", wraps.size(), qa.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [15:0] g;
        logic [48:0] gb, e;
        fill(1'b0);
        clear_logs();
        tick(1'b1, 1'b1);
        t0 = cyc;
        repeat (8) tick(1'b0, 1'b1);
        total++;
        if (qa.size() != 4) begin bad++; $display("FAIL rstmid_pre_beats: got %0d want 4", qa.size()); end
        rst = 1'b1;
        #1;
        g = {wrap_a, rd_a, if_a.valid, if_a.last, busy_a, done_a, ovr_a, if_a.data};
        total++;
        if (g !== 16'h0) begin bad++; $display("FAIL rstmid_outs: got %h want 0", g); end
        repeat (2) tick(1'b0, 1'b1);
        rst = 1'b0;
        clear_logs();
        repeat (10) tick(1'b0, 1'b1);
        total++;
        if (qa.size() != 0 || rdcnt != 0) begin
            bad++; $display("FAIL rstmid_no_stale: beats=%0d rd=%0d want 0/0", qa.size(), rdcnt);
        end
        tick(1'b1, 1'b1);
        t0 = cyc;
        repeat (20) tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            e  = {8'h00, mem[i], (i == 7), t0 + 4 + i};
            gb = (i < qa.size()) ? {qa[i].data, qa[i].last, qa[i].cyc} : 'x;
            total++;
            if (gb !== e) begin bad++; $display("FAIL rstmid_replay%0d: got %h want %h", i, gb, e); end
        end
    endtask

    initial begin
        clear_logs();
        repeat (2) @(posedge clk);
        test_reset();
        test_nominal();
        test_backpressure(1'b0);
        test_backpressure(1'b1);
        test_wide();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_fifo_drain.md
# vec_fifo_drain

Read-side drain engine for a VecFIFO holding a finished output vector. When the producer (MVProd) signals `out_vector_valid`, the block rewinds the FIFO read pointer and reads every chunk. It streams the chunks out on a valid/ready byte-lane interface with a `last` marker. It sits between the MVProd output FIFO and the next layer's loader or host egress. It is the reader counterpart of MVProd's `req_chunk_out` write path.

## Interface
- `VecElements`, default 8: bytes per vector; must be a multiple of `BytesPerRead`. Elaboration fails otherwise.
- `BytesPerRead`, default 1: bytes returned per FIFO read, and also the output beat width.
- Derived constant `Beats = VecElements / BytesPerRead`.

Ports:
- `clk_in`  in  1  single clock, all logic on rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `vec_valid_in`  in  1  one-cycle pulse: a complete vector is in the FIFO.
- `fifo_wrap_rd`  out  1  one-cycle pulse that rewinds the FIFO read pointer to element 0.
- `fifo_rd_en`  out  1  chunk read request.
- `fifo_rd_data`  in  `[BytesPerRead][8]`  chunk; valid the cycle after `fifo_rd_en` (fixed 1-cycle read latency).
- `m_data`  out  `[BytesPerRead][8]`  output beat.
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  downstream accept.
- `m_last`  out  1  high with the final beat of a vector.
- `busy_out`  out  1  high in any state except IDLE.
- `drain_done`  out  1  one-cycle pulse after the last beat is accepted.
- `overrun`  out  1  sticky; a `vec_valid_in` arrived while one request was already pending. Cleared only by reset.

## Operation
- FSM states: IDLE, WRAP, READ, FLUSH.
- IDLE:
  - If `vec_valid_in` or the pending flag is set, go to WRAP and clear pending.
- WRAP:
  - Assert `fifo_wrap_rd` for exactly one cycle.
  - Clear the issue and emit counters.
  - Go to READ.
- READ:
  - Assert `fifo_rd_en` when `issued < Beats` and `occ + inflight - pop < 2`.
    - `occ` is the buffer occupancy (0..2).
    - `inflight` is a read issued last cycle.
    - `pop` is `m_valid & m_ready` this cycle.
  - After issue `Beats` has been made, go to FLUSH.
- FLUSH:
  - Wait until the last beat is accepted.
  - Pulse `drain_done`.
  - Return to IDLE.
- Return data is captured into a 2-entry skid buffer at the end of the cycle after `fifo_rd_en`.
- `m_valid` = buffer non-empty; `m_data` = buffer head.
- `m_last` = `m_valid` and head beat index == `Beats-1`. The index is tracked by the emit counter, width `$clog2(Beats+1)`.
- `m_data` and `m_last` hold stable while `m_valid & !m_ready`. The buffer never overflows, guaranteed by the credit rule.
- `vec_valid_in` while busy or pending:
  - First occurrence: set pending, depth 1.
  - Further occurrences while pending is set: ignored, and `overrun` set.
  - `vec_valid_in` in the same cycle as `drain_done` counts as pending, so no request is lost.
- Reset (any time, including mid-vector):
  - FSM goes to IDLE.
  - Buffer emptied; counters and pending cleared.
  - All outputs 0: `fifo_wrap_rd`, `fifo_rd_en`, `m_valid`, `m_last`, `busy_out`, `drain_done`, `overrun`, `m_data`.
  - Stale in-flight read data is discarded.

## Timing
- Cycle 0: `vec_valid_in`.
- Cycle 1: `fifo_wrap_rd`.
- Cycle 2: first `fifo_rd_en`.
- Cycle 3: data on `fifo_rd_data`.
- Cycle 4: first `m_valid`.
- With `m_ready` held high, one beat per cycle, no bubbles. The last beat is at cycle `3+Beats` and `drain_done` at cycle `4+Beats`.
- `fifo_rd_en` never asserts in the same cycle as `fifo_wrap_rd`.
- `busy_out` rises cycle 1 and falls in the cycle after `drain_done`.
- Throughput: 1 beat/cycle sustained; latency from `vec_valid_in` to first beat is 4 cycles.

## Structure
- Package `vec_pkg`:
  - typedef `byte_t = logic [7:0]`.
  - enum `drain_state_t` {IDLE, WRAP, READ, FLUSH}.
  - helper function computing `Beats`.
- Sub-module `byte_skid_buf`: 2-entry register FIFO, parameterised on `BytesPerRead`, exposing push/pop/occupancy.
- FSM, counters and credit logic live in `vec_fifo_drain`.

## Test plan
- Nominal drain:
  - Setup: `VecElements=8`, `BytesPerRead=1`, FIFO preloaded 0..7; pulse `vec_valid_in`, `m_ready=1`.
  - Expected: beats 0,1,…,7 on cycles 4–11; `m_last` only with 7; `drain_done` at cycle 12; exactly 8 `fifo_rd_en`.
- Backpressure:
  - Setup: same data, `m_ready` toggling 1,0,0,1,…
  - Expected: sequence still 0..7 with no loss or duplication; `m_data` stable while stalled; `fifo_rd_en` suppressed once 2 entries are held.
- Wide reads:
  - Setup: `BytesPerRead=2`, FIFO holding 0..7.
  - Expected: 4 beats {0,1},{2,3},{4,5},{6,7}; `m_last` on {6,7}.
- Back-to-back request:
  - Setup: second `vec_valid_in` mid-READ.
  - Expected: second drain starts (`fifo_wrap_rd`) the cycle after return to IDLE; `overrun=0`.
  - Setup: third pulse while still pending.
  - Expected: `overrun=1`.
- Reset mid-vector:
  - Setup: assert `rst_in` after beat 3.
  - Expected: all outputs 0 within the reset cycle; no further beats; a fresh `vec_valid_in` replays 0..7 from the start.
